// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : Owns the fetch PC, issues single-outstanding word reads to
//               instruction memory and buffers {pc, instr} for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
  parameter int              XLEN       = 64,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_instr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0]       c_IDLE     = 2'd0;
  localparam logic [1:0]       c_WAIT     = 2'd1;
  localparam logic [1:0]       c_DISCARD  = 2'd2;
  localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] c_DEPTH_M1 = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W-1:0] c_LAST     = PTR_W'(FIFO_DEPTH - 1);

  logic [1:0]       r_state;
  logic [XLEN-1:0]  r_fetch_pc;
  logic             r_req;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [XLEN-1:0]  r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]      r_fifo_instr [FIFO_DEPTH];

  logic             w_push;
  logic             w_pop;
  logic             w_reissue;
  logic [XLEN-1:0]  w_pc_next;
  logic [XLEN-1:0]  w_redirect_aligned;

  function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_push             = (r_state == c_WAIT) && imem_rvalid && !redirect_valid;
  assign w_pop              = (r_count != '0) && if_ready;
  // Registered count only: a pop this cycle is not credited, so the slot stays reserved.
  assign w_reissue          = (r_count < c_DEPTH_M1);
  assign w_pc_next          = r_fetch_pc + XLEN'(4);
  assign w_redirect_aligned = redirect_pc & ~(XLEN'(3));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_count    <= '0;
      r_head     <= '0;
      r_tail     <= '0;
    end else begin
      r_req <= 1'b0;
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_aligned;
        r_count    <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        // A response still in flight must be absorbed before the new path may issue.
        case (r_state)
          c_WAIT, c_DISCARD: r_state <= imem_rvalid ? c_IDLE : c_DISCARD;
          default:           r_state <= c_IDLE;
        endcase
      end else begin
        case (r_state)
          c_IDLE: begin
            if (r_count < c_DEPTH) begin
              r_req   <= 1'b1;
              r_state <= c_WAIT;
            end
          end
          c_WAIT: begin
            if (imem_rvalid) begin
              r_fetch_pc <= w_pc_next;
              if (w_reissue) begin
                r_req <= 1'b1;
              end else begin
                r_state <= c_IDLE;
              end
            end
          end
          c_DISCARD: begin
            if (imem_rvalid) begin
              r_state <= c_IDLE;
            end
          end
          default: r_state <= c_IDLE;
        endcase

        if (w_push) begin
          r_tail <= f_ptr_inc(r_tail);
        end
        if (w_pop) begin
          r_head <= f_ptr_inc(r_head);
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_tail]    <= r_fetch_pc;
      r_fifo_instr[r_tail] <= imem_rdata;
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_fetch_pc >> 2;
  assign if_valid  = (r_count != '0);
  assign if_pc     = r_fifo_pc[r_head];
  assign if_instr  = r_fifo_instr[r_head];

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Directed bench with a variable-latency instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

  localparam logic [63:0] c_RPC1 = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_ready;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;

  logic        req0, req1, v0, v1;
  logic [63:0] addr0, addr1, pc0, pc1;
  logic [31:0] ins0, ins1;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          lat      = 1;
  int          m_cnt    = 0;
  logic        m_seen   = 1'b0;
  logic [63:0] m_addr   = '0;
  logic [63:0] m_ra     = '0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .FIFO_DEPTH(2)) u_dut0 (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(req0), .imem_addr(addr0), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(v0), .if_ready(if_ready), .if_pc(pc0), .if_instr(ins0)
  );

  instruction_fetch_unit #(.XLEN(64), .RESET_PC(c_RPC1), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(req1), .imem_addr(addr1), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(v1), .if_ready(if_ready), .if_pc(pc1), .if_instr(ins1)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Memory: request seen at negedge, data returned lat cycles later.
  always @(negedge clk) begin
    if (req0 && !reset) begin
      m_seen = 1'b1;
      m_addr = addr0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (reset) begin
      m_cnt  = 0;
      m_seen = 1'b0;
    end else begin
      if (m_seen) begin
        m_cnt  = lat;
        m_ra   = m_addr;
        m_seen = 1'b0;
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(m_ra);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int k_req, k_pop, cyc;
    logic got_req;

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if_ready       = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", v0, 1'b0);
    check("rst_req", req0, 1'b0);
    check("rst_addr0", addr0, 64'h0);
    check("rst_addr1", addr1, c_RPC1 >> 2);

    // Streaming with 1-cycle memory, decode always ready; dut1 wraps past 2^64
    if_ready = 1'b1;
    k_req = 0; k_pop = 0; cyc = 0;
    while (k_pop < 4 && cyc < 60) begin
      tick();
      cyc++;
      if (req0) begin
        check("t1_addr0", addr0, 64'(k_req));
        check("t1_addr1", addr1, (c_RPC1 + 64'(4 * k_req)) >> 2);
        k_req++;
      end
      if (v0) begin
        check("t1_pc0", pc0, 64'(4 * k_pop));
        check("t1_ins0", ins0, mem_word(64'(k_pop)));
        check("t1_pc1", pc1, c_RPC1 + 64'(4 * k_pop));
        k_pop++;
      end
    end
    check("t1_done", k_pop, 4);

    // Back-pressure: buffer fills, requests stop, order kept on release
    do_reset();
    repeat (8) tick();
    check("t2_valid", v0, 1'b1);
    check("t2_req", req0, 1'b0);
    check("t2_addr", addr0, 64'h2);
    check("t2_head", pc0, 64'h0);
    tick();
    check("t2_hold", pc0, 64'h0);
    if_ready = 1'b1;
    k_pop = 0; cyc = 0;
    while (k_pop < 3 && cyc < 40) begin
      if (v0) begin
        check("t2_pc", pc0, 64'(4 * k_pop));
        k_pop++;
      end
      tick();
      cyc++;
    end
    check("t2_done", k_pop, 3);

    // Redirect while a slow response is outstanding
    lat = 3;
    do_reset();
    if_ready = 1'b1;
    cyc = 0;
    while (!req0 && cyc < 20) begin tick(); cyc++; end
    check("t3_req_seen", req0, 1'b1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3A0;
    tick();
    redirect_valid = 1'b0;
    got_req = 1'b0; cyc = 0;
    while (!v0 && cyc < 40) begin
      if (req0 && !got_req) begin
        check("t3_addr", addr0, 64'hE8);
        got_req = 1'b1;
      end
      tick();
      cyc++;
    end
    check("t3_got_req", got_req, 1'b1);
    check("t3_pc", pc0, 64'h3A0);
    check("t3_ins", ins0, mem_word(64'hE8));

    // Redirect coincident with pop and response
    lat = 1;
    do_reset();
    cyc = 0;
    while (!(v0 && imem_rvalid) && cyc < 20) begin tick(); cyc++; end
    check("t4_setup", v0 & imem_rvalid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h3A2;
    if_ready       = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("t4_flushed", v0, 1'b0);
    cyc = 0;
    while (!v0 && cyc < 20) begin tick(); cyc++; end
    check("t4_pc0", pc0, 64'h3A0);
    check("t4_ins0", ins0, mem_word(64'hE8));
    check("t4_pc1", pc1, 64'h3A0);

    // Reset in WAIT with a buffered entry
    lat = 3;
    do_reset();
    cyc = 0;
    while (!(v0 && req0) && cyc < 30) begin tick(); cyc++; end
    check("t6_setup", v0 & req0, 1'b1);
    reset = 1'b1;
    tick();
    check("t6_valid", v0, 1'b0);
    check("t6_req", req0, 1'b0);
    check("t6_addr0", addr0, 64'h0);
    check("t6_addr1", addr1, c_RPC1 >> 2);
    reset    = 1'b0;
    if_ready = 1'b1;
    cyc = 0;
    while (!v0 && cyc < 30) begin tick(); cyc++; end
    check("t6_pc0", pc0, 64'h0);
    check("t6_ins0", ins0, mem_word(64'h0));
    check("t6_pc1", pc1, c_RPC1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
